// File: rtl/ysyx_23060203_exu_pkg.sv
// Shared encodings for the execute unit: op kinds, ALU function codes and
// the output-register state.
package ysyx_23060203_exu_pkg;

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_BRANCH = 2'd1,
    OP_JAL    = 2'd2,
    OP_JALR   = 2'd3
  } exu_op_e;

  // funct selects the operation; funcs picks SUB over ADD and SRA over SRL
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_LTS = 3'b010;
  localparam logic [2:0] ALU_LTU = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SR  = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } exu_state_e;

endpackage

// File: rtl/ysyx_23060203_exu_alu.sv
// Combinational 32-bit ALU shared by every op kind of the execute unit.
module ysyx_23060203_ALU
  import ysyx_23060203_exu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct,
  input  logic        funcs,
  output logic [31:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (funct)
      ALU_ADD: result = funcs ? (a - b) : (a + b);
      ALU_SLL: result = a << shamt;
      ALU_LTS: result = {31'b0, $signed(a) < $signed(b)};
      ALU_LTU: result = {31'b0, a < b};
      ALU_XOR: result = a ^ b;
      ALU_SR:  result = funcs ? 32'($signed(a) >>> shamt) : (a >> shamt);
      ALU_OR:  result = a | b;
      ALU_AND: result = a & b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060203_exu.sv
// Execute unit: one-entry writeback register with valid/ready handshakes,
// branch resolution and a registered one-cycle redirect to the fetch unit.
//
// state   | meaning
// S_EMPTY | no record held, out_valid=0
// S_FULL  | record held for WBU, out_valid=1
module ysyx_23060203_exu
  import ysyx_23060203_exu_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_alu_a,
  input  logic [31:0] in_alu_b,
  input  logic [2:0]  in_alu_funct,
  input  logic        in_alu_funcs,
  input  logic [1:0]  in_op,
  input  logic [2:0]  in_br_funct3,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic [31:0] out_data,
  output logic        jump_valid,
  output logic [31:0] jump_pc
);

  exu_state_e  state;
  exu_op_e     op;
  logic [31:0] alu_val;
  logic        in_fire, out_fire;
  logic        br_cond, br_taken, jump_req;
  logic [31:0] target_sum, target;

  assign op = exu_op_e'(in_op);

  ysyx_23060203_ALU u_alu (
    .a      (in_alu_a),
    .b      (in_alu_b),
    .funct  (in_alu_funct),
    .funcs  (in_alu_funcs),
    .result (alu_val)
  );

  assign out_valid = (state == S_FULL);
  assign in_ready  = !out_valid | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // IDU routes XOR (eq/ne) or LTS/LTU (lt/ge) through the ALU; funct3 01x never branches
  assign br_cond  = in_br_funct3[2] ? alu_val[0] : (alu_val == '0);
  assign br_taken = (br_cond ^ in_br_funct3[0]) & (in_br_funct3[2:1] != 2'b01);

  assign target_sum = ((op == OP_JALR) ? in_rs1 : in_pc) + in_imm;
  assign target     = (op == OP_JALR) ? {target_sum[31:1], 1'b0} : target_sum;
  assign jump_req   = (op == OP_JAL) | (op == OP_JALR) | ((op == OP_BRANCH) & br_taken);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_EMPTY;
      out_rd     <= '0;
      out_wen    <= 1'b0;
      out_data   <= '0;
      jump_valid <= 1'b0;
      jump_pc    <= '0;
    end else begin
      jump_valid <= in_fire & jump_req;
      if (in_fire & jump_req) jump_pc <= target;
      case (state)
        S_EMPTY: if (in_fire) state <= S_FULL;
        S_FULL:  if (!in_fire && out_fire) state <= S_EMPTY;
        default: state <= S_EMPTY;
      endcase
      if (in_fire) begin
        out_rd   <= in_rd;
        out_wen  <= (op != OP_BRANCH) & (in_rd != 5'd0);
        out_data <= alu_val;
      end
    end
  end

endmodule
